// File: rtl/axis_byte_remove_pkt_if.sv
// Stream-in, remove-count and stream-out channels of the packet head-byte remover.
// The slave modport is the remover's view; the master modport is the surrounding logic's view.
interface axis_byte_remove_pkt_if #(
    parameter int unsigned DATA_WD       = 32,
    parameter int unsigned DATA_BYTE_WD  = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD   = $clog2(DATA_BYTE_WD),
    parameter int unsigned REMOVE_CNT_WD = BYTE_CNT_WD + 2
);
    logic                     valid_in;
    logic [DATA_WD-1:0]       data_in;
    logic [DATA_BYTE_WD-1:0]  keep_in;
    logic                     last_in;
    logic                     ready_in;

    logic                     valid_out;
    logic [DATA_WD-1:0]       data_out;
    logic [DATA_BYTE_WD-1:0]  keep_out;
    logic                     last_out;
    logic                     ready_out;

    logic                     valid_remove;
    logic [REMOVE_CNT_WD-1:0] byte_remove_cnt;
    logic                     ready_remove;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, ready_out, valid_remove, byte_remove_cnt,
        output ready_in, valid_out, data_out, keep_out, last_out, ready_remove
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, ready_out, valid_remove, byte_remove_cnt,
        input  ready_in, valid_out, data_out, keep_out, last_out, ready_remove
    );
endinterface

// File: rtl/axis_byte_remove_pkt.sv
// Strips a per-packet count of leading bytes (possibly several beats) and realigns the rest.
// Optional packet statistics counters are enabled with `define BYTE_REMOVE_STATS_EN.
module axis_byte_remove_pkt #(
    parameter int unsigned DATA_WD       = 32,
    parameter int unsigned DATA_BYTE_WD  = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD   = $clog2(DATA_BYTE_WD),
    parameter int unsigned REMOVE_CNT_WD = BYTE_CNT_WD + 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    axis_byte_remove_pkt_if.slave bus
`ifdef BYTE_REMOVE_STATS_EN
    ,
    output logic [31:0]           stat_pkt_out,
    output logic [31:0]           stat_pkt_drop
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        DROP,
        HEAD,
        SHIFT,
        FLUSH
    } state_e;

    localparam logic [REMOVE_CNT_WD-1:0] BYTES_L = REMOVE_CNT_WD'(DATA_BYTE_WD);

    state_e                    state_q, state_d;
    logic [REMOVE_CNT_WD-1:0]  drop_cnt_q, drop_cnt_d;
    logic [BYTE_CNT_WD-1:0]    shift_q, shift_d;
    logic [DATA_WD-1:0]        hold_q, hold_d;
    logic [DATA_BYTE_WD-1:0]   hold_keep_q, hold_keep_d;
    logic                      valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]        data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0]   keep_out_q, keep_out_d;
    logic                      last_out_q, last_out_d;

    logic                      ready_in;
    logic                      ready_remove;
    logic                      out_free;
    logic                      fire_in;
    logic                      fire_remove;
    logic [DATA_BYTE_WD-1:0]   keep_eff;
    logic [BYTE_CNT_WD:0]      keep_pop;
    logic                      tail_left;

    // Window of DATA_WD bits starting sh bytes into the concatenation {hi, lo}.
    function automatic logic [DATA_WD-1:0] align_data(
        input logic [DATA_WD-1:0]     hi,
        input logic [DATA_WD-1:0]     lo,
        input logic [BYTE_CNT_WD-1:0] sh
    );
        logic [2*DATA_WD-1:0] wide;
        wide = {hi, lo} << {sh, 3'b000};
        return wide[2*DATA_WD-1 -: DATA_WD];
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] align_keep(
        input logic [DATA_BYTE_WD-1:0] hi,
        input logic [DATA_BYTE_WD-1:0] lo,
        input logic [BYTE_CNT_WD-1:0]  sh
    );
        logic [2*DATA_BYTE_WD-1:0] wide;
        wide = {hi, lo} << sh;
        return wide[2*DATA_BYTE_WD-1 -: DATA_BYTE_WD];
    endfunction

    assign ready_remove = (state_q == IDLE);
    assign out_free     = !valid_out_q || bus.ready_out;
    assign fire_in      = bus.valid_in && ready_in;
    assign fire_remove  = bus.valid_remove && ready_remove;
    // Only the closing beat carries a partial keep; every earlier beat counts as full.
    assign keep_eff     = bus.last_in ? bus.keep_in : '1;
    assign tail_left    = keep_pop > {1'b0, shift_q};

    always_comb begin
        keep_pop = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            keep_pop = keep_pop + (BYTE_CNT_WD + 1)'(bus.keep_in[i]);
        end
    end

    always_comb begin
        ready_in = 1'b0;
        case (state_q)
            DROP, HEAD: ready_in = 1'b1;
            SHIFT:      ready_in = out_free;
            default:    ready_in = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        drop_cnt_d  = drop_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_keep_d = hold_keep_q;
        valid_out_d = valid_out_q && !bus.ready_out;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;

        case (state_q)
            IDLE: begin
                if (fire_remove) begin
                    drop_cnt_d = bus.byte_remove_cnt / BYTES_L;
                    shift_d    = BYTE_CNT_WD'(bus.byte_remove_cnt % BYTES_L);
                    state_d    = ((bus.byte_remove_cnt / BYTES_L) != '0) ? DROP : HEAD;
                end
            end
            DROP: begin
                if (fire_in) begin
                    if (bus.last_in) begin
                        state_d = IDLE;
                    end else begin
                        drop_cnt_d = drop_cnt_q - REMOVE_CNT_WD'(1);
                        if (drop_cnt_q == REMOVE_CNT_WD'(1)) begin
                            state_d = HEAD;
                        end
                    end
                end
            end
            HEAD: begin
                if (fire_in) begin
                    hold_d      = bus.data_in;
                    hold_keep_d = keep_eff;
                    if (bus.last_in) begin
                        state_d = tail_left ? FLUSH : IDLE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (fire_in) begin
                    valid_out_d = 1'b1;
                    data_out_d  = align_data(hold_q, bus.data_in, shift_q);
                    keep_out_d  = align_keep(hold_keep_q, keep_eff, shift_q);
                    last_out_d  = bus.last_in && !tail_left;
                    hold_d      = bus.data_in;
                    hold_keep_d = keep_eff;
                    if (bus.last_in) begin
                        state_d = tail_left ? FLUSH : IDLE;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = align_data(hold_q, '0, shift_q);
                    keep_out_d  = align_keep(hold_keep_q, '0, shift_q);
                    last_out_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            drop_cnt_q  <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_keep_q <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_cnt_q  <= drop_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_keep_q <= hold_keep_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
        end
    end

    assign bus.ready_in     = ready_in;
    assign bus.ready_remove = ready_remove;
    assign bus.valid_out    = valid_out_q;
    assign bus.data_out     = data_out_q;
    assign bus.keep_out     = keep_out_q;
    assign bus.last_out     = last_out_q;

`ifdef BYTE_REMOVE_STATS_EN
    logic [31:0] stat_out_q, stat_out_d;
    logic [31:0] stat_drop_q, stat_drop_d;
    logic        drop_evt;

    // A packet vanishes when its last beat lands in DROP, or in HEAD with nothing past the shift.
    always_comb begin
        drop_evt    = fire_in && bus.last_in &&
                      ((state_q == DROP) || ((state_q == HEAD) && !tail_left));
        stat_out_d  = stat_out_q;
        stat_drop_d = stat_drop_q;
        if (valid_out_q && bus.ready_out && last_out_q && (stat_out_q != '1)) begin
            stat_out_d = stat_out_q + 32'd1;
        end
        if (drop_evt && (stat_drop_q != '1)) begin
            stat_drop_d = stat_drop_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_out_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_out_q  <= stat_out_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_pkt_out  = stat_out_q;
    assign stat_pkt_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_axis_byte_remove_pkt.sv
// Bench for axis_byte_remove_pkt: directed packet table, hand-written corner sequences and
// random packets, all checked against a byte-queue model of the head-removal rules.
`timescale 1ns/1ps
module tb_axis_byte_remove_pkt;
    localparam int unsigned DW = 32;
    localparam int unsigned NB = DW / 8;
    localparam int unsigned RW = $clog2(NB) + 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    axis_byte_remove_pkt_if #(.DATA_WD(DW)) bus ();

`ifdef BYTE_REMOVE_STATS_EN
    logic [31:0] stat_pkt_out;
    logic [31:0] stat_pkt_drop;
    int unsigned exp_pkts  = 0;
    int unsigned exp_drops = 0;
    axis_byte_remove_pkt #(.DATA_WD(DW)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .stat_pkt_out(stat_pkt_out), .stat_pkt_drop(stat_pkt_drop)
    );
`else
    axis_byte_remove_pkt #(.DATA_WD(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        int unsigned cnt;
        int unsigned nbeats;
        int unsigned last_bytes;
        int unsigned bp;
        int unsigned exp_bytes;
        int unsigned exp_beats;
    } vec_t;

    beat_t       exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned bp_mode = 0;
    int unsigned pkt_bytes = 0;
    int unsigned pkt_beats = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int unsigned popc(input logic [NB-1:0] k);
        int unsigned c = 0;
        for (int unsigned i = 0; i < NB; i++) c += int'(k[i]);
        return c;
    endfunction

    // Output monitor: drives ready_out, checks every fired beat and stall stability.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic [NB-1:0] prev_k;
    logic          prev_l;
    always begin
        @(negedge clk);
        case (bp_mode)
            0:       bus.ready_out = 1'b1;
            1:       bus.ready_out = !bus.ready_out;
            2:       bus.ready_out = 1'($urandom_range(0, 1));
            default: bus.ready_out = 1'b0;
        endcase
        #2;
        if (rstn) begin
            if (prev_stall) begin
                check("stall_hold", {27'd0, bus.valid_out, bus.data_out, bus.keep_out, bus.last_out},
                      {27'd0, 1'b1, prev_d, prev_k, prev_l});
            end
            if (bus.valid_out && bus.ready_out) begin
                logic [DW-1:0] mask;
                beat_t e;
                mask = '0;
                for (int unsigned i = 0; i < NB; i++) if (bus.keep_out[i]) mask[i*8 +: 8] = 8'hFF;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {27'd0, bus.data_out & mask, bus.keep_out, bus.last_out},
                          {27'd0, e.data, e.keep, e.last});
                end
                pkt_bytes += popc(bus.keep_out);
                pkt_beats++;
            end
            prev_stall = bus.valid_out && !bus.ready_out;
            prev_d = bus.data_out;
            prev_k = bus.keep_out;
            prev_l = bus.last_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference: drop the first cnt bytes of the packet, re-chunk the rest into full beats.
    task automatic model_pkt(input logic [7:0] pb[$], input int unsigned cnt);
        int unsigned k = 0;
        beat_t e;
        e.data = '0; e.keep = '0; e.last = 1'b0;
        for (int unsigned i = cnt; i < pb.size(); i++) begin
            e.data[DW-1-8*k -: 8] = pb[i];
            e.keep[NB-1-k] = 1'b1;
            k++;
            if (k == NB || i == pb.size() - 1) begin
                e.last = (i == pb.size() - 1);
                exp_q.push_back(e);
                e.data = '0; e.keep = '0; e.last = 1'b0;
                k = 0;
            end
        end
`ifdef BYTE_REMOVE_STATS_EN
        if (pb.size() > cnt) exp_pkts++; else exp_drops++;
`endif
    endtask

    // Drivers start and return on a negative clock edge.
    task automatic do_remove(input int unsigned cnt);
        bit done = 0;
        bus.valid_remove    = 1'b1;
        bus.byte_remove_cnt = RW'(cnt);
        for (int i = 0; i < 300 && !done; i++) begin
            #1;
            if (bus.ready_remove) done = 1;
            @(negedge clk);
        end
        bus.valid_remove = 1'b0;
        if (!done) check("remove_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
        bit done = 0;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.keep_in  = k;
        bus.last_in  = l;
        for (int i = 0; i < 300 && !done; i++) begin
            #1;
            if (bus.ready_in) done = 1;
            @(negedge clk);
        end
        bus.valid_in = 1'b0;
        if (!done) check("beat_timeout", 64'd1, 64'd0);
    endtask

    task automatic send_pkt(input int unsigned cnt, input int unsigned nb, input int unsigned lb,
                            input bit gaps);
        logic [7:0]    pb[$];
        int unsigned   total;
        logic [DW-1:0] d;
        logic [NB-1:0] k;
        total = (nb - 1) * NB + lb;
        for (int unsigned i = 0; i < total; i++) pb.push_back(8'($urandom));
        model_pkt(pb, cnt);
        do_remove(cnt);
        for (int unsigned b = 0; b < nb; b++) begin
            d = '0; k = '0;
            for (int unsigned j = 0; j < NB; j++) begin
                if (b * NB + j < total) begin
                    d[DW-1-8*j -: 8] = pb[b*NB+j];
                    k[NB-1-j] = 1'b1;
                end else begin
                    d[DW-1-8*j -: 8] = 8'($urandom);
                end
            end
            do_beat(d, k, b == nb - 1);
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic drain();
        int i = 0;
        while ((exp_q.size() != 0 || bus.valid_out) && i < 600) begin
            @(negedge clk);
            i++;
        end
        if (i == 600) check("drain_timeout", 64'd1, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[11];

    initial begin
        int unsigned rand_exp_bytes;

        vecs[0]  = '{1, 2, 4, 0, 7, 2};
        vecs[1]  = '{5, 3, 4, 0, 7, 2};
        vecs[2]  = '{3, 1, 2, 0, 0, 0};
        vecs[3]  = '{0, 2, 1, 0, 5, 2};
        vecs[4]  = '{2, 4, 4, 1, 14, 4};
        vecs[5]  = '{4, 2, 4, 0, 4, 1};
        vecs[6]  = '{6, 2, 2, 0, 0, 0};
        vecs[7]  = '{15, 4, 4, 0, 1, 1};
        vecs[8]  = '{2, 2, 2, 2, 4, 1};
        vecs[9]  = '{1, 1, 4, 0, 3, 1};
        vecs[10] = '{8, 2, 4, 0, 0, 0};

        rstn = 1'b0;
        bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
        bus.valid_remove = 1'b0; bus.byte_remove_cnt = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state",
              {24'd0, bus.valid_out, bus.last_out, bus.data_out, bus.keep_out, bus.ready_in, bus.ready_remove},
              {24'd0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b1});
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            bp_mode = vecs[v].bp;
            pkt_bytes = 0;
            pkt_beats = 0;
            send_pkt(vecs[v].cnt, vecs[v].nbeats, vecs[v].last_bytes, 1'b0);
            drain();
            check($sformatf("vec%0d_bytes", v), 64'(pkt_bytes), 64'(vecs[v].exp_bytes));
            check($sformatf("vec%0d_beats", v), 64'(pkt_beats), 64'(vecs[v].exp_beats));
        end

        // Whole packet consumed: count channel reopens immediately, nothing emitted.
        bp_mode = 0;
        pkt_beats = 0;
        send_pkt(3, 1, 2, 1'b0);
        #1;
        check("drop_ready_remove", {62'd0, bus.ready_remove, bus.valid_out}, {62'd0, 1'b1, 1'b0});
        @(negedge clk);
        drain();
        check("drop_no_beats", 64'(pkt_beats), 64'd0);

        // Reset mid-packet with an output beat parked behind ready_out low.
        bp_mode = 3;
        @(negedge clk);
        do_remove(1);
        do_beat(DW'($urandom), '1, 1'b0);
        do_beat(DW'($urandom), '1, 1'b0);
        rstn = 1'b0;
        #1;
        check("midpkt_reset",
              {24'd0, bus.valid_out, bus.last_out, bus.data_out, bus.keep_out, bus.ready_in, bus.ready_remove},
              {24'd0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b1});
`ifdef BYTE_REMOVE_STATS_EN
        exp_pkts  = 0;
        exp_drops = 0;
`endif
        @(negedge clk);
        rstn = 1'b1;
        bp_mode = 0;
        @(negedge clk);
        pkt_bytes = 0;
        pkt_beats = 0;
        send_pkt(0, 2, 3, 1'b0);
        drain();
        check("post_reset_bytes", 64'(pkt_bytes), 64'd7);
        check("post_reset_beats", 64'(pkt_beats), 64'd2);

        // Random packets with random input gaps and output backpressure.
        pkt_bytes = 0;
        rand_exp_bytes = 0;
        for (int p = 0; p < 60; p++) begin
            int unsigned cnt, nb, lb, total;
            cnt = $urandom_range(0, 15);
            nb  = $urandom_range(1, 5);
            lb  = $urandom_range(1, NB);
            total = (nb - 1) * NB + lb;
            if (total > cnt) rand_exp_bytes += total - cnt;
            bp_mode = $urandom_range(0, 1) * 2;
            send_pkt(cnt, nb, lb, 1'b1);
        end
        bp_mode = 2;
        drain();
        check("random_bytes", 64'(pkt_bytes), 64'(rand_exp_bytes));

`ifdef BYTE_REMOVE_STATS_EN
        check("stat_pkt_out", 64'(stat_pkt_out), 64'(exp_pkts));
        check("stat_pkt_drop", 64'(stat_pkt_drop), 64'(exp_drops));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
